cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// Write-back cache controller: services one CPU load/store at a time through a
// handshaked cache access port and a handshaked backing-memory port.
module cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [0:10] addr,
  input  logic [0:15] wdata,
  output logic [0:15] rdata,
  output logic        done,
  output logic        busy,
  output logic        c_enable,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  output logic        c_rst,
  output logic [0:3]  c_index,
  output logic [0:1]  c_word,
  output logic [0:4]  c_tag_in,
  output logic [0:15] c_data_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic        c_ack,
  input  logic [0:4]  c_tag_out,
  input  logic [0:15] c_data_out,
  output logic        m_en,
  output logic        m_wr,
  output logic [0:10] m_addr,
  output logic [0:15] m_wdata,
  input  logic [0:15] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [2:0] {
    INIT, IDLE, CMP, WB_RD, WB_WR, FILL_RD, FILL_WR, GAP
  } state_t;

  state_t      state_reg, state_next;
  state_t      ret_reg, ret_next;
  logic [0:1]  k_reg, k_next;
  logic        wr_reg, wr_next;
  logic [0:10] addr_reg, addr_next;
  logic [0:15] wdata_reg, wdata_next;
  logic [0:4]  victim_reg, victim_next;
  logic [0:15] buf_reg, buf_next;
  logic [0:15] rdata_reg, rdata_next;
  logic        done_reg, done_next;

  logic [0:4]  tag;
  logic [0:3]  index;
  logic [0:1]  word;

  assign tag   = addr_reg[0:4];
  assign index = addr_reg[5:8];
  assign word  = addr_reg[9:10];

  assign rdata = rdata_reg;
  assign done  = done_reg;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= INIT;
      ret_reg    <= IDLE;
      k_reg      <= '0;
      wr_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      victim_reg <= '0;
      buf_reg    <= '0;
      rdata_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ret_reg    <= ret_next;
      k_reg      <= k_next;
      wr_reg     <= wr_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      victim_reg <= victim_next;
      buf_reg    <= buf_next;
      rdata_reg  <= rdata_next;
      done_reg   <= done_next;
    end
  end

  // Every completed access detours through GAP, so an enable is always low for
  // at least one cycle after its ack and the two ports can never overlap.
  always_comb begin
    state_next  = state_reg;
    ret_next    = ret_reg;
    k_next      = k_reg;
    wr_next     = wr_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    victim_next = victim_reg;
    buf_next    = buf_reg;
    rdata_next  = rdata_reg;
    done_next   = 1'b0;

    c_enable    = 1'b0;
    c_comp      = 1'b0;
    c_write     = 1'b0;
    c_valid_in  = 1'b0;
    c_rst       = 1'b0;
    c_index     = '0;
    c_word      = '0;
    c_tag_in    = '0;
    c_data_in   = '0;
    m_en        = 1'b0;
    m_wr        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;

    case (state_reg)
      INIT: begin
        c_enable = 1'b1;
        c_rst    = 1'b1;
        if (c_ack) begin
          state_next = GAP;
          ret_next   = IDLE;
        end
      end

      IDLE: begin
        if (req) begin
          wr_next    = wr;
          addr_next  = addr;
          wdata_next = wdata;
          state_next = CMP;
        end
      end

      CMP: begin
        c_enable   = 1'b1;
        c_comp     = 1'b1;
        c_write    = wr_reg;
        c_valid_in = 1'b1;
        c_index    = index;
        c_word     = word;
        c_tag_in   = tag;
        c_data_in  = wdata_reg;
        if (c_ack) begin
          state_next = GAP;
          k_next     = '0;
          if (c_hit && c_valid) begin
            if (!wr_reg) begin
              rdata_next = c_data_out;
            end
            done_next = 1'b1;
            ret_next  = IDLE;
          end else if (c_valid && c_dirty) begin
            victim_next = c_tag_out;
            ret_next    = WB_RD;
          end else begin
            ret_next = FILL_RD;
          end
        end
      end

      WB_RD: begin
        c_enable = 1'b1;
        c_index  = index;
        c_word   = k_reg;
        c_tag_in = tag;
        if (c_ack) begin
          buf_next   = c_data_out;
          state_next = GAP;
          ret_next   = WB_WR;
        end
      end

      WB_WR: begin
        m_en    = 1'b1;
        m_wr    = 1'b1;
        m_addr  = {victim_reg, index, k_reg};
        m_wdata = buf_reg;
        if (m_ack) begin
          state_next = GAP;
          if (k_reg == 2'd3) begin
            k_next   = '0;
            ret_next = FILL_RD;
          end else begin
            k_next   = k_reg + 2'd1;
            ret_next = WB_RD;
          end
        end
      end

      FILL_RD: begin
        m_en   = 1'b1;
        m_addr = {tag, index, k_reg};
        if (m_ack) begin
          buf_next   = m_rdata;
          state_next = GAP;
          ret_next   = FILL_WR;
        end
      end

      FILL_WR: begin
        c_enable   = 1'b1;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        c_index    = index;
        c_word     = k_reg;
        c_tag_in   = tag;
        c_data_in  = buf_reg;
        if (c_ack) begin
          state_next = GAP;
          if (k_reg == 2'd3) begin
            k_next   = '0;
            ret_next = CMP;
          end else begin
            k_next   = k_reg + 2'd1;
            ret_next = FILL_RD;
          end
        end
      end

      GAP: begin
        state_next = ret_reg;
      end

      default: begin
        state_next = INIT;
      end
    endcase
  end

endmodule
